// File: rtl/spram_arbiter.sv
// Two-port arbiter for a single-port RAM with an async read path. Port 0 (video) has priority.
// Port 1 (CPU) gets a turn once port 0 has taken MAX_STREAK slots in a row while it waited.
module spram_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic              wr0_i,
  input  logic              wr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              ack0_o,
  output logic              ack1_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic              ram_clken_o,
  output logic              ram_wren_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_q_i,
  output logic              busy_o
);

  localparam int unsigned StreakW = $clog2(MAX_STREAK + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_STREAK);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e              state_q;
  logic [StreakW-1:0]  streak_q;
  logic                gnt_q;
  logic                wr_q;
  logic                clken_q;
  logic                ack0_q;
  logic                ack1_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   rdata0_q;
  logic [DATA_W-1:0]   rdata1_q;
  logic                pick1;

  // Port 1 wins when alone, or when port 0 has used up its streak allowance.
  always_comb begin
    pick1 = req1_i & (~req0_i | (streak_q == StreakMax));
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      streak_q <= '0;
      gnt_q    <= 1'b0;
      wr_q     <= 1'b0;
      clken_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req0_i | req1_i) begin
            gnt_q   <= pick1;
            wr_q    <= pick1 ? wr1_i : wr0_i;
            addr_q  <= pick1 ? addr1_i : addr0_i;
            data_q  <= pick1 ? wdata1_i : wdata0_i;
            clken_q <= 1'b1;
            state_q <= StAccess;
            if (pick1 || !req1_i) begin
              streak_q <= '0;
            end else if (streak_q != StreakMax) begin
              streak_q <= streak_q + StreakW'(1);
            end
          end else begin
            streak_q <= '0;
          end
        end
        StAccess: begin
          clken_q <= 1'b0;
          state_q <= StDone;
          ack0_q  <= ~gnt_q;
          ack1_q  <= gnt_q;
          if (!wr_q) begin
            if (gnt_q) rdata1_q <= ram_q_i;
            else       rdata0_q <= ram_q_i;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ack0_o      = ack0_q;
  assign ack1_o      = ack1_q;
  assign rdata0_o    = rdata0_q;
  assign rdata1_o    = rdata1_q;
  assign ram_clken_o = clken_q;
  // A reset arriving during ACCESS must not let the RAM write on that same edge.
  assign ram_wren_o  = clken_q & wr_q & ~reset_i;
  assign ram_addr_o  = addr_q;
  assign ram_data_o  = data_q;
  assign busy_o      = (state_q != StIdle);

endmodule
